// File: rtl/bec_operand_loader_pkg.sv
// bec_pkg: shared constants and types for the BEC operand loader.
//   FIELD_W/LO_W/HI_W : operand width and the split into the low and high frame halves.
//   NUM_OPS           : number of operands; frame tags run 0..2*NUM_OPS-1.
//   state_t           : loader FSM states.
//   err_t             : err_code values.
//   W1..KEY           : operand index (frame_tag >> 1).
package bec_pkg;

  localparam int FIELD_W = 163;
  localparam int LO_W    = 82;
  localparam int HI_W    = FIELD_W - LO_W;
  localparam int NUM_OPS = 7;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 8;

  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(2*NUM_OPS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, ARMED, RUN, ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_ORDER, ERR_PARITY, ERR_RUN
  } err_t;

  localparam int W1 = 0, Z1 = 1, W2 = 2, Z2 = 3, INV_W0 = 4, D = 5, KEY = 6;

  // Operand index addressed by a frame tag; even tags carry the high half.
  function automatic logic [2:0] tag_op(input logic [TAG_W-1:0] tag);
    return tag[TAG_W-1:1];
  endfunction

endpackage

// File: rtl/bec_operand_loader_key_shifter.sv
// bec_key_shifter: scalar key register plus the count of key bits still to serve.
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_ld_hi/i_ld_lo : write key bits [162:82] from i_data[80:0] / bits [81:0] from i_data
//   i_arm           : reload keys_left with the full field width
//   i_shift         : shift key right (zero fill) and count one bit served
//   o_key_bit       : key LSB, combinational
//   o_keys_left     : remaining key bits, saturates at 0
module bec_key_shifter
  import bec_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_ld_hi,
  input  logic                i_ld_lo,
  input  logic [LO_W-1:0]     i_data,
  input  logic                i_arm,
  input  logic                i_shift,
  output logic                o_key_bit,
  output logic [CNT_W-1:0]    o_keys_left
);

  logic [FIELD_W-1:0] r_key;
  logic [CNT_W-1:0]   r_left;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key <= '0;
    end else if (i_shift) begin
      r_key <= r_key >> 1;
    end else begin
      if (i_ld_hi) r_key[FIELD_W-1:LO_W] <= i_data[HI_W-1:0];
      if (i_ld_lo) r_key[LO_W-1:0]       <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_left <= '0;
    else if (i_arm)                    r_left <= CNT_W'(FIELD_W);
    else if (i_shift && r_left != '0)  r_left <= r_left - 1'b1;
  end

  assign o_key_bit   = r_key[0];
  assign o_keys_left = r_left;

endmodule

// File: rtl/bec_operand_loader.sv
// bec_operand_loader: assembles the seven 163-bit BEC operands from 82-bit frames,
// arms the core, and serves key bits during the run.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_start               : begin load / start run / recover from error
//   i_frame_valid/tag/data: frame input; even tag 2k = operand k high half, odd = low half
//   i_frame_par           : even parity over frame data (BEC_LOADER_PARITY_EN only)
//   i_key_shift           : next key bit request from the core
//   i_core_done           : core finished; back to IDLE
//   o_frame_ack           : one-cycle ack, cycle after an accepted frame
//   o_w1..o_d             : operand registers
//   o_key_bit/o_keys_left : current key LSB and bits remaining
//   o_core_enable         : high while running
//   o_load_done/o_load_err/o_err_code : ARMED, ERROR, error cause
// Optional build macro BEC_LOADER_PARITY_EN: reject frames whose parity mismatches.
module bec_operand_loader
  import bec_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_frame_valid,
  input  logic [TAG_W-1:0]   i_frame_tag,
  input  logic [LO_W-1:0]    i_frame_data,
  input  logic               i_frame_par,
  input  logic               i_key_shift,
  input  logic               i_core_done,
  output logic               o_frame_ack,
  output logic [FIELD_W-1:0] o_w1,
  output logic [FIELD_W-1:0] o_z1,
  output logic [FIELD_W-1:0] o_w2,
  output logic [FIELD_W-1:0] o_z2,
  output logic [FIELD_W-1:0] o_inv_w0,
  output logic [FIELD_W-1:0] o_d,
  output logic               o_key_bit,
  output logic [CNT_W-1:0]   o_keys_left,
  output logic               o_core_enable,
  output logic               o_load_done,
  output logic               o_load_err,
  output logic [1:0]         o_err_code
);

  state_t             r_state, w_state_nxt;
  err_t               r_err, w_err_nxt;
  logic [TAG_W-1:0]   r_exp_tag, w_exp_tag_nxt;
  logic               r_ack;
  logic               w_accept, w_arm, w_shift, w_par_ok, w_hi;
  logic [2:0]         w_op;

  // Non-key operands; the key lives in the shifter.
  logic [NUM_OPS-2:0][FIELD_W-1:0] r_ops;

`ifdef BEC_LOADER_PARITY_EN
  assign w_par_ok = ((^i_frame_data) == i_frame_par);
`else
  logic w_unused_par;
  assign w_unused_par = i_frame_par;
  assign w_par_ok     = 1'b1;
`endif

  assign w_op = tag_op(i_frame_tag);
  assign w_hi = ~i_frame_tag[0];

  always_comb begin
    w_state_nxt   = r_state;
    w_err_nxt     = r_err;
    w_exp_tag_nxt = r_exp_tag;
    w_accept      = 1'b0;
    w_arm         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt   = LOAD;
          w_exp_tag_nxt = '0;
        end
      end
      LOAD: begin
        // start wins over a coincident frame: the sequence restarts at tag 0
        if (i_start) begin
          w_exp_tag_nxt = '0;
        end else if (i_frame_valid) begin
          if (!w_par_ok) begin
            w_state_nxt = ERROR;
            w_err_nxt   = ERR_PARITY;
          end else if (i_frame_tag != r_exp_tag) begin
            w_state_nxt = ERROR;
            w_err_nxt   = ERR_ORDER;
          end else begin
            w_accept      = 1'b1;
            w_exp_tag_nxt = r_exp_tag + 1'b1;
            if (i_frame_tag == LAST_TAG) begin
              w_state_nxt = ARMED;
              w_arm       = 1'b1;
            end
          end
        end
      end
      ARMED: begin
        if (i_start) w_state_nxt = RUN;
      end
      RUN: begin
        if (i_frame_valid) begin
          w_state_nxt = ERROR;
          w_err_nxt   = ERR_RUN;
        end else if (i_core_done) begin
          w_state_nxt = IDLE;
        end
      end
      ERROR: begin
        if (i_start) begin
          w_state_nxt   = LOAD;
          w_err_nxt     = ERR_NONE;
          w_exp_tag_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Key shifts in RUN regardless of a coincident core_done or stray frame.
  assign w_shift = (r_state == RUN) && i_key_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_err     <= ERR_NONE;
      r_exp_tag <= '0;
      r_ack     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_err     <= w_err_nxt;
      r_exp_tag <= w_exp_tag_nxt;
      r_ack     <= w_accept;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ops <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < NUM_OPS - 1; k++) begin
        if (w_op == 3'(k)) begin
          if (w_hi) r_ops[k][FIELD_W-1:LO_W] <= i_frame_data[HI_W-1:0];
          else      r_ops[k][LO_W-1:0]       <= i_frame_data;
        end
      end
    end
  end

  bec_key_shifter u_key (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ld_hi     (w_accept && (w_op == 3'(KEY)) && w_hi),
    .i_ld_lo     (w_accept && (w_op == 3'(KEY)) && !w_hi),
    .i_data      (i_frame_data),
    .i_arm       (w_arm),
    .i_shift     (w_shift),
    .o_key_bit   (o_key_bit),
    .o_keys_left (o_keys_left)
  );

  assign o_frame_ack   = r_ack;
  assign o_w1          = r_ops[W1];
  assign o_z1          = r_ops[Z1];
  assign o_w2          = r_ops[W2];
  assign o_z2          = r_ops[Z2];
  assign o_inv_w0      = r_ops[INV_W0];
  assign o_d           = r_ops[D];
  assign o_core_enable = (r_state == RUN);
  assign o_load_done   = (r_state == ARMED);
  assign o_load_err    = (r_state == ERROR);
  assign o_err_code    = r_err;

endmodule

// File: tb/tb_bec_operand_loader.sv
// Randomized bench for bec_operand_loader against a behavioural model of the
// load/arm/run/error protocol. Operands are held as whole 163-bit values and the
// key as a value shifted right once per served bit.
module tb_bec_operand_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0, fv = 1'b0, par = 1'b0, ks = 1'b0, cd = 1'b0;
  logic [3:0]   tag = '0;
  logic [81:0]  data = '0;

  logic         o_ack, o_kb, o_cen, o_ldone, o_lerr;
  logic [162:0] o_w1, o_z1, o_w2, o_z2, o_inv, o_d;
  logic [7:0]   o_left;
  logic [1:0]   o_err;

  always #5 clk = ~clk;

  bec_operand_loader dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_valid(fv),
    .i_frame_tag(tag), .i_frame_data(data), .i_frame_par(par),
    .i_key_shift(ks), .i_core_done(cd),
    .o_frame_ack(o_ack), .o_w1(o_w1), .o_z1(o_z1), .o_w2(o_w2), .o_z2(o_z2),
    .o_inv_w0(o_inv), .o_d(o_d), .o_key_bit(o_kb), .o_keys_left(o_left),
    .o_core_enable(o_cen), .o_load_done(o_ldone), .o_load_err(o_lerr),
    .o_err_code(o_err)
  );

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_ARMED = 2, M_RUN = 3, M_ERR = 4;
  int           m_mode, m_exp, m_left, m_err;
  logic         m_ack;
  logic [162:0] m_op [7];   // index 6 is the key, shifted as bits are served
  logic [162:0] stim [7];

  int n_vec = 0, n_mis = 0;

  task automatic chk(input string name, input logic [162:0] got, input logic [162:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_exp = 0; m_left = 0; m_err = 0; m_ack = 1'b0;
    for (int i = 0; i < 7; i++) m_op[i] = '0;
  endtask

  task automatic model_step(input logic s, v, input logic [3:0] t, input logic [81:0] dt,
                            input logic p, k, c);
    logic bad_par;
`ifdef BEC_LOADER_PARITY_EN
    bad_par = ((^dt) != p);
`else
    bad_par = 1'b0;
`endif
    m_ack = 1'b0;
    case (m_mode)
      M_IDLE:  if (s) begin m_mode = M_LOAD; m_exp = 0; end
      M_LOAD: begin
        if (s) m_exp = 0;
        else if (v) begin
          if (bad_par)              begin m_mode = M_ERR; m_err = 2; end
          else if (int'(t) != m_exp) begin m_mode = M_ERR; m_err = 1; end
          else begin
            if (t % 2 == 0) m_op[t/2][162:82] = dt[80:0];
            else            m_op[t/2][81:0]   = dt;
            m_ack = 1'b1;
            m_exp++;
            if (m_exp == 14) begin m_mode = M_ARMED; m_left = 163; end
          end
        end
      end
      M_ARMED: if (s) m_mode = M_RUN;
      M_RUN: begin
        if (k) begin
          m_op[6] = m_op[6] >> 1;
          if (m_left > 0) m_left--;
        end
        if (v)      begin m_mode = M_ERR; m_err = 3; end
        else if (c) m_mode = M_IDLE;
      end
      default: if (s) begin m_mode = M_LOAD; m_err = 0; m_exp = 0; end
    endcase
  endtask

  task automatic check_all();
    chk("ack",         o_ack,   m_ack);
    chk("load_done",   o_ldone, m_mode == M_ARMED);
    chk("load_err",    o_lerr,  m_mode == M_ERR);
    chk("core_enable", o_cen,   m_mode == M_RUN);
    chk("err_code",    o_err,   m_err);
    chk("keys_left",   o_left,  m_left);
    chk("key_bit",     o_kb,    m_op[6][0]);
    chk("w1",          o_w1,    m_op[0]);
    chk("z1",          o_z1,    m_op[1]);
    chk("w2",          o_w2,    m_op[2]);
    chk("z2",          o_z2,    m_op[3]);
    chk("inv_w0",      o_inv,   m_op[4]);
    chk("d",           o_d,     m_op[5]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic s, v, input logic [3:0] t, input logic [81:0] dt,
                     input logic k, c, badp);
    @(negedge clk);
    start = s; fv = v; tag = t; data = dt; par = (^dt) ^ badp; ks = k; cd = c;
    model_step(s, v, t, dt, par, k, c);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'd0, '0, 0, 0, 0);
  endtask

  task automatic go();                       cyc(1, 0, 4'd0, '0, 0, 0, 0); endtask
  task automatic frame(input int t, input logic [81:0] dt); cyc(0, 1, 4'(t), dt, 0, 0, 0); endtask
  task automatic shift(input logic c);       cyc(0, 0, 4'd0, '0, 1, c, 0); endtask

  task automatic rand_stim();
    for (int k = 0; k < 7; k++)
      stim[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Send all 14 frames in order; with gaps, idle cycles are sprinkled between them.
  task automatic load_all(input bit gaps);
    for (int k = 0; k < 7; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle(1);
      frame(2*k, {1'b0, stim[k][162:82]});
      if (gaps && $urandom_range(0, 2) == 0) idle(1);
      frame(2*k + 1, stim[k][81:0]);
    end
  endtask

  task automatic finish_run();
    for (int i = 0; i < 4; i++) if (m_mode == M_RUN) cyc(0, 0, 4'd0, '0, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #6 check_all();                          // reset state
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // frames in IDLE are ignored
    frame(0, 82'h123);
    idle(1);

    // out-of-order: tag 0 then tag 2
    go();
    frame(0, 82'h1_2345);
    frame(2, 82'h777);
    idle(2);
    chk("ooo_w1_lo", o_w1[81:0], 82'h0);

    // directed full load, back-to-back frames
    go();
    for (int k = 0; k < 7; k++) begin
      logic [80:0] hi;
      logic [81:0] lo;
      hi = 81'h1 << k;
      lo = 82'hA5 + 82'(k);
      stim[k] = {hi, lo};
    end
    load_all(0);
    idle(1);
    chk("plan_w1", o_w1, {81'h1, 82'hA5});
    chk("plan_left", o_left, 8'd163);
    go(); finish_run();                      // ARMED -> RUN -> IDLE

    // key serving with key low half 5, then simultaneous shift + done
    rand_stim();
    stim[6][81:0] = 82'h5;
    go(); load_all(1);
    go();
    chk("kb0", o_kb, 1'b1);
    shift(0); chk("kb1", o_kb, 1'b0);
    shift(0); chk("kb2", o_kb, 1'b1);
    shift(0); chk("kb3", o_kb, 1'b0);
    chk("left160", o_left, 8'd160);
    shift(1);
    chk("sim_left", o_left, 8'd159);
    chk("sim_cen", o_cen, 1'b0);
    idle(1);

    // frame during RUN, then recovery
    rand_stim();
    go(); load_all(1);
    go(); shift(0);
    frame(1, 82'h9);
    chk("run_err", o_err, 2'd3);
    idle(1);
    go();
    chk("recover_err", o_err, 2'd0);

    // restart mid-load, then keys_left saturation over a long run
    rand_stim();
    for (int t = 0; t < 4; t++) frame(t, 82'(t + 1));
    go();
    load_all(0);
    go();
    for (int i = 0; i < 170; i++) shift(0);
    chk("left_sat", o_left, 8'd0);
    finish_run();

    // randomized load/run cycles with occasional wrong tags
    for (int it = 0; it < 20; it++) begin
      bit inject;
      int at;
      rand_stim();
      inject = ($urandom_range(0, 4) == 0);
      at     = $urandom_range(0, 13);
      go();
      for (int t = 0; t < 14; t++) begin
        logic [81:0] dt;
        dt = (t % 2 == 0) ? {1'b0, stim[t/2][162:82]} : stim[t/2][81:0];
        if ($urandom_range(0, 3) == 0) idle(1);
        if (inject && t == at) frame((t + $urandom_range(1, 15)) % 16, dt);
        else                   frame(t, dt);
      end
      go();
      for (int i = 0; i < int'($urandom_range(0, 12)); i++)
        cyc(0, 0, 4'd0, '0, 1'($urandom_range(0, 1)), 0, 0);
      cyc(0, 0, 4'd0, '0, 1'($urandom_range(0, 1)), 1, 0);
      idle(1);
    end

    // asynchronous reset after tag 5
    go();
    for (int t = 0; t < 6; t++) frame(t, {$urandom, $urandom, 18'($urandom)});
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_w1", o_w1, '0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

`ifdef BEC_LOADER_PARITY_EN
    go();
    cyc(0, 1, 4'd0, 82'h3, 0, 0, 1);
    chk("parity_err", o_err, 2'd2);
    idle(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
